// File: rtl/reg_file.sv
// Architectural register file with rename tags: resolves issue operands to a
// committed value, a commit/ROB forward, or a pending ROB tag.
module reg_file #(
    parameter int ROB_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        IS_rs1,
    input  logic [4:0]        IS_rs2,
    input  logic              IS_sgn,
    input  logic [4:0]        IS_rd,
    input  logic [ROB_AW-1:0] IS_ROB_name,
    output logic [ROB_AW-1:0] REG_ord1,
    output logic [ROB_AW-1:0] REG_ord2,
    input  logic              REG_rdy1,
    input  logic              REG_rdy2,
    input  logic [31:0]       REG_val1,
    input  logic [31:0]       REG_val2,
    output logic              OP_rdy1,
    output logic              OP_rdy2,
    output logic [31:0]       OP_val1,
    output logic [31:0]       OP_val2,
    output logic [ROB_AW-1:0] OP_tag1,
    output logic [ROB_AW-1:0] OP_tag2,
    input  logic              CM_sgn,
    input  logic [4:0]        CM_dest,
    input  logic [31:0]       CM_value,
    input  logic [ROB_AW-1:0] CM_ROB_name,
    input  logic              clr
);

    logic [31:0]       regs_q [32];
    logic [31:0]       regs_d [32];
    logic [31:0]       busy_q;
    logic [31:0]       busy_d;
    logic [ROB_AW-1:0] tag_q  [32];
    logic [ROB_AW-1:0] tag_d  [32];

    logic [4:0]        src     [2];
    logic              rob_rdy [2];
    logic [31:0]       rob_val [2];
    logic              op_rdy  [2];
    logic [31:0]       op_val  [2];
    logic [ROB_AW-1:0] op_tag  [2];

    assign src[0]     = IS_rs1;
    assign src[1]     = IS_rs2;
    assign rob_rdy[0] = REG_rdy1;
    assign rob_rdy[1] = REG_rdy2;
    assign rob_val[0] = REG_val1;
    assign rob_val[1] = REG_val2;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            op_rdy[n] = 1'b1;
            op_val[n] = '0;
            op_tag[n] = '0;
            if (src[n] == 5'd0) begin
                op_val[n] = '0;
            end else if (!busy_q[src[n]]) begin
                op_val[n] = regs_q[src[n]];
            end else if (CM_sgn && CM_dest == src[n] && CM_ROB_name == tag_q[src[n]]) begin
                op_val[n] = CM_value;
            end else if (rob_rdy[n]) begin
                op_val[n] = rob_val[n];
            end else begin
                op_rdy[n] = 1'b0;
                op_tag[n] = tag_q[src[n]];
            end
        end
    end

    assign OP_rdy1  = op_rdy[0];
    assign OP_rdy2  = op_rdy[1];
    assign OP_val1  = op_val[0];
    assign OP_val2  = op_val[1];
    assign OP_tag1  = op_tag[0];
    assign OP_tag2  = op_tag[1];
    assign REG_ord1 = tag_q[IS_rs1];
    assign REG_ord2 = tag_q[IS_rs2];

    // Commit first, then flush/rename override busy and tag for the same entry.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (CM_sgn && CM_dest != 5'd0) begin
                regs_d[CM_dest] = CM_value;
                if (tag_q[CM_dest] == CM_ROB_name) begin
                    busy_d[CM_dest] = 1'b0;
                end
            end
            if (clr) begin
                busy_d = '0;
            end else if (IS_sgn && IS_rd != 5'd0) begin
                busy_d[IS_rd] = 1'b1;
                tag_d[IS_rd]  = IS_ROB_name;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file against an array-based model of
// the architectural/rename state.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy;
    logic [4:0]  is_rs1, is_rs2, is_rd, cm_dest;
    logic        is_sgn, cm_sgn, clr;
    logic [3:0]  is_name, cm_name;
    logic        reg_rdy1, reg_rdy2;
    logic [31:0] reg_val1, reg_val2, cm_value;
    logic [3:0]  reg_ord1, reg_ord2, op_tag1, op_tag2;
    logic        op_rdy1, op_rdy2;
    logic [31:0] op_val1, op_val2;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    reg_file #(.ROB_AW(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IS_rs1(is_rs1), .IS_rs2(is_rs2), .IS_sgn(is_sgn), .IS_rd(is_rd),
        .IS_ROB_name(is_name),
        .REG_ord1(reg_ord1), .REG_ord2(reg_ord2),
        .REG_rdy1(reg_rdy1), .REG_rdy2(reg_rdy2),
        .REG_val1(reg_val1), .REG_val2(reg_val2),
        .OP_rdy1(op_rdy1), .OP_rdy2(op_rdy2),
        .OP_val1(op_val1), .OP_val2(op_val2),
        .OP_tag1(op_tag1), .OP_tag2(op_tag2),
        .CM_sgn(cm_sgn), .CM_dest(cm_dest), .CM_value(cm_value),
        .CM_ROB_name(cm_name), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic void model_op(input logic [4:0] s, input logic rr, input logic [31:0] rv,
                                     output logic r, output logic [31:0] v, output logic [3:0] t);
        r = 1'b1;
        v = '0;
        t = '0;
        if (s == 5'd0) v = '0;
        else if (!m_busy[s]) v = m_regs[s];
        else if (cm_sgn && cm_dest == s && cm_name == m_tag[s]) v = cm_value;
        else if (rr) v = rv;
        else begin
            r = 1'b0;
            t = m_tag[s];
        end
    endfunction

    task automatic model_edge();
        if (!rdy) return;
        if (cm_sgn && cm_dest != 5'd0) begin
            m_regs[cm_dest] = cm_value;
            if (m_tag[cm_dest] == cm_name) m_busy[cm_dest] = 1'b0;
        end
        if (clr) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (is_sgn && is_rd != 5'd0) begin
            m_busy[is_rd] = 1'b1;
            m_tag[is_rd]  = is_name;
        end
    endtask

    task automatic idle();
        rdy = 1'b1; is_sgn = 1'b0; cm_sgn = 1'b0; clr = 1'b0;
        is_rs1 = '0; is_rs2 = '0; is_rd = '0; is_name = '0;
        cm_dest = '0; cm_name = '0; cm_value = '0;
        reg_rdy1 = 1'b0; reg_rdy2 = 1'b0; reg_val1 = '0; reg_val2 = '0;
    endtask

    // Compare all combinational outputs against the model for the current inputs.
    task automatic settle();
        logic r; logic [31:0] v; logic [3:0] t;
        #3;
        model_op(is_rs1, reg_rdy1, reg_val1, r, v, t);
        check("op_rdy1", 32'(op_rdy1), 32'(r));
        check("op_val1", op_val1, v);
        check("op_tag1", 32'(op_tag1), 32'(t));
        check("reg_ord1", 32'(reg_ord1), 32'(m_tag[is_rs1]));
        model_op(is_rs2, reg_rdy2, reg_val2, r, v, t);
        check("op_rdy2", 32'(op_rdy2), 32'(r));
        check("op_val2", op_val2, v);
        check("op_tag2", 32'(op_tag2), 32'(t));
        check("reg_ord2", 32'(reg_ord2), 32'(m_tag[is_rs2]));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    initial begin
        model_reset();
        idle();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state and plain commit
        is_rs1 = 5; is_rs2 = 6; settle();
        check("rst_rdy1", 32'(op_rdy1), 32'd1);
        check("rst_val2", op_val2, 32'd0);
        clock_edge();
        idle(); cm_sgn = 1; cm_dest = 5; cm_value = 32'h1234; cm_name = 0; step();
        idle(); is_rs1 = 5; settle();
        check("x5_commit", op_val1, 32'h1234);
        clock_edge();

        // Rename then ROB forward
        idle(); is_sgn = 1; is_rd = 3; is_name = 7; step();
        idle(); is_rs1 = 3; settle();
        check("x3_tag7", 32'(op_tag1), 32'd7);
        check("x3_ord7", 32'(reg_ord1), 32'd7);
        reg_rdy1 = 1; reg_val1 = 32'hAA; settle();
        check("x3_fwd", op_val1, 32'hAA);
        clock_edge();

        // Stale commit leaves newer producer busy
        idle(); is_sgn = 1; is_rd = 3; is_name = 2; step();
        idle(); is_sgn = 1; is_rd = 3; is_name = 5; step();
        idle(); cm_sgn = 1; cm_dest = 3; cm_name = 2; cm_value = 32'h11; step();
        idle(); is_rs1 = 3; settle();
        check("x3_still_busy", 32'(op_rdy1), 32'd0);
        check("x3_tag5", 32'(op_tag1), 32'd5);
        clock_edge();
        idle(); cm_sgn = 1; cm_dest = 3; cm_name = 5; cm_value = 32'h22; step();
        idle(); is_rs1 = 3; settle();
        check("x3_final", op_val1, 32'h22);
        clock_edge();

        // Commit bypass, then commit+rename same register
        idle(); is_sgn = 1; is_rd = 4; is_name = 1; step();
        idle(); cm_sgn = 1; cm_dest = 4; cm_name = 1; cm_value = 32'h99; is_rs1 = 4; settle();
        check("x4_bypass", op_val1, 32'h99);
        clock_edge();
        idle(); cm_sgn = 1; cm_dest = 4; cm_name = 1; cm_value = 32'h99;
        is_sgn = 1; is_rd = 4; is_name = 3; step();
        idle(); is_rs1 = 4; settle();
        check("x4_renamed", 32'(op_tag1), 32'd3);
        clock_edge();

        // Flush with simultaneous rename
        idle(); is_sgn = 1; is_rd = 8; is_name = 8; step();
        idle(); is_sgn = 1; is_rd = 9; is_name = 9; step();
        idle(); clr = 1; is_sgn = 1; is_rd = 10; is_name = 10; step();
        idle(); is_rs1 = 8; is_rs2 = 9; step();
        idle(); is_rs1 = 10; is_rs2 = 4; settle();
        check("x10_flushed", 32'(op_rdy1), 32'd1);
        clock_edge();

        // x0 is hard-wired
        idle(); is_sgn = 1; is_rd = 0; is_name = 6; cm_sgn = 1; cm_dest = 0; cm_value = 32'hFFFF; step();
        idle(); settle();
        check("x0_val", op_val1, 32'd0);
        clock_edge();

        // Asynchronous reset while x3 busy
        idle(); is_sgn = 1; is_rd = 3; is_name = 6; step();
        idle(); is_rs1 = 3; #2;
        rst = 1'b1; #1;
        model_reset();
        check("arst_rdy", 32'(op_rdy1), 32'd1);
        check("arst_val", op_val1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 29) == 0);
            is_sgn   = $urandom_range(0, 1);
            is_rd    = 5'($urandom_range(0, 31));
            is_name  = 4'($urandom_range(0, 15));
            cm_sgn   = $urandom_range(0, 1);
            cm_dest  = 5'($urandom_range(0, 31));
            cm_name  = ($urandom_range(0, 1) != 0) ? m_tag[cm_dest] : 4'($urandom_range(0, 15));
            cm_value = $urandom;
            is_rs1   = ($urandom_range(0, 3) == 0) ? cm_dest : 5'($urandom_range(0, 31));
            is_rs2   = ($urandom_range(0, 3) == 0) ? is_rd : 5'($urandom_range(0, 31));
            reg_rdy1 = $urandom_range(0, 1);
            reg_rdy2 = $urandom_range(0, 1);
            reg_val1 = $urandom;
            reg_val2 = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename-tag tracking for the out-of-order RISC-V core. It sits between the issue stage and the reorder buffer (ROB). On the read side it resolves source operands to either a committed value or a pending ROB tag, querying the ROB for early results. On the write side it records the new producer tag of each issued destination and retires values that the ROB commits in order.

## Interface
- ROB_AW, 4, ROB index width; tag fields are ROB_AW bits wide.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, no state changes (reset still acts).
- IS_rs1, IS_rs2  in  5  source register indices presented by issue.
- IS_sgn  in  1  an instruction is issued this cycle.
- IS_rd  in  5  destination register of the issued instruction.
- IS_ROB_name  in  ROB_AW  ROB entry allocated to the issued instruction.
- REG_ord1, REG_ord2  out  ROB_AW  tags of rs1/rs2, sent to the ROB for readiness lookup.
- REG_rdy1, REG_rdy2  in  1  ROB entry ready flags for REG_ord1/2 (combinational).
- REG_val1, REG_val2  in  32  ROB entry values for REG_ord1/2 (combinational).
- OP_rdy1, OP_rdy2  out  1  operand is available now.
- OP_val1, OP_val2  out  32  operand value; valid when OP_rdyN=1, otherwise 0.
- OP_tag1, OP_tag2  out  ROB_AW  producer tag; meaningful when OP_rdyN=0, otherwise 0.
- CM_sgn  in  1  ROB commits an entry this cycle.
- CM_dest  in  5  committed destination register.
- CM_value  in  32  committed value.
- CM_ROB_name  in  ROB_AW  ROB entry being committed.
- clr  in  1  misprediction flush: drop all pending renames.

## Operation
- State: regs[0:31] (32 b), busy[0:31] (1 b), tag[0:31] (ROB_AW b). Entry 0 is never written and never busy.
- Operand resolution, combinational, for each N in {1,2} with source s = IS_rsN:
  - s==0 -> rdy=1, val=0.
  - !busy[s] -> rdy=1, val=regs[s].
  - busy[s] and CM_sgn, CM_dest==s, CM_ROB_name==tag[s] -> rdy=1, val=CM_value (commit bypass).
  - busy[s] and REG_rdyN -> rdy=1, val=REG_valN (ROB forward).
  - otherwise rdy=0, tag=tag[s].
- REG_ordN = tag[IS_rsN] always, regardless of busy.
- Commit: on CM_sgn with CM_dest!=0, regs[CM_dest] <= CM_value. busy[CM_dest] clears only if tag[CM_dest]==CM_ROB_name, meaning no newer producer exists.
- Rename: on IS_sgn with IS_rd!=0 and clr=0, busy[IS_rd] <= 1 and tag[IS_rd] <= IS_ROB_name.
- Same-cycle commit and rename of the same register: the regs write happens, and rename wins for busy and tag.
- Flush: clr=1 clears every busy bit. The same-cycle commit regs write still applies. A same-cycle rename is dropped. tag contents are don't-care after a flush.
- Issue sources read pre-edge state. An instruction whose rs equals its own rd sees the previous producer, not itself.

## Timing
- Reset, asynchronous: regs=0, busy=0, tag=0. Outputs then read OP_rdyN=1, OP_valN=0, OP_tagN=0, REG_ordN=0.
- Operand outputs are combinational, with zero-cycle latency from IS_rsN, CM_* and REG_rdyN/REG_valN.
- Rename and commit take effect on the edge where IS_sgn/CM_sgn is sampled high with rdy=1. They are visible to reads in the next cycle.
- rdy=0: IS_sgn, CM_sgn and clr are ignored, and combinational outputs still track the current state.
- Reset asserted mid-operation returns all state to reset values immediately, independent of clk.

## Test plan
- Reset, then read x5/x6 -> OP_rdy=1, OP_val=0. Commit x5=0x1234 (tag 0, not busy) -> next cycle x5 reads 0x1234.
- Issue rd=x3, ROB 7. Next cycle read x3 with REG_rdy1=0 -> OP_rdy1=0, OP_tag1=7, REG_ord1=7. Then with REG_rdy1=1, REG_val1=0xAA -> OP_rdy1=1, OP_val1=0xAA.
- Rename x3 to ROB 2, then to ROB 5. Commit ROB 2 with value 0x11 -> regs[x3]=0x11, x3 still busy with tag 5. Commit ROB 5 with 0x22 -> x3 not busy, reads 0x22.
- Same cycle: commit x4 (ROB 1, 0x99) and read x4 whose tag is 1 -> OP_rdy=1, OP_val=0x99 via bypass. Same cycle: commit x4 ROB 1 and rename x4 to ROB 3 -> regs[x4]=0x99, busy=1, tag=3.
- Rename x8/x9, then assert clr with a simultaneous rename of x10 -> all three read not-busy, each with its last committed value.
- Issue and commit to x0 with value 0xFFFF -> x0 reads 0 and is never busy.
- Assert rst asynchronously between edges while x3 is busy -> x3 immediately reads rdy=1, val=0.
